// File: rtl/pattern_detector_param_if.sv
// Serial-stream and configuration bundle for pattern_detector_param.
// Optional cfg_mask is present only when MATCH_MASK_EN is defined.
interface pattern_detector_param_if #(
  parameter int PAT_W = 5,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
);
  // Handshake: in_valid qualifies stream_in for one clock; there is no ready,
  // the detector accepts every qualified bit, and cfg_load takes priority.
  logic             in_valid;
  logic             stream_in;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             clr_count;
`ifdef MATCH_MASK_EN
  logic [PAT_W-1:0] cfg_mask;
`endif
  logic             pattern_found;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
`ifdef MATCH_MASK_EN
    output cfg_mask,
`endif
    output in_valid, stream_in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  pattern_found, match_count, count_sat
  );

  modport slave (
`ifdef MATCH_MASK_EN
    input  cfg_mask,
`endif
    input  in_valid, stream_in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output pattern_found, match_count, count_sat
  );
endinterface

// File: rtl/pattern_detector_param.sv
// Programmable serial pattern detector (length 1..PAT_W) with saturating match counter.
// Define MATCH_MASK_EN to add per-bit don't-care masking via cfg_mask.
module pattern_detector_param #(
  parameter int               PAT_W       = 5,
  parameter int               LEN_W       = 3,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 5'b11010
) (
  input logic                     clk,
  input logic                     reset,
  pattern_detector_param_if.slave bus
);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             found;
  logic [CNT_W-1:0] count;
  logic             sat;

`ifdef MATCH_MASK_EN
  logic [PAT_W-1:0] mask;
`else
  localparam logic [PAT_W-1:0] mask = '1;
`endif

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] load_len;
  logic             match;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], bus.stream_in};
    fill_next = (fill == FULL_LEN) ? fill : fill + 1'b1;
    len_mask  = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len)) len_mask[i] = 1'b1;
    end
    // Only the newest len bits take part; masked positions never mismatch.
    match = bus.in_valid && !bus.cfg_load && (fill_next >= len) &&
            (((hist_next ^ pat) & len_mask & mask) == '0);
    load_len = ((bus.cfg_len == '0) || (bus.cfg_len > FULL_LEN)) ? FULL_LEN : bus.cfg_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pat     <= DEF_PATTERN;
      len     <= FULL_LEN;
      overlap <= 1'b1;
`ifdef MATCH_MASK_EN
      mask    <= '1;
`endif
      found   <= 1'b0;
      count   <= '0;
      sat     <= 1'b0;
    end else begin
      found <= match;
      if (bus.cfg_load) begin
        pat     <= bus.cfg_pattern;
        len     <= load_len;
        overlap <= bus.cfg_overlap;
`ifdef MATCH_MASK_EN
        mask    <= bus.cfg_mask;
`endif
        hist    <= '0;
        fill    <= '0;
      end else if (bus.in_valid) begin
        hist <= hist_next;
        // Non-overlapping mode demands a full set of fresh bits after each hit.
        fill <= (match && !overlap) ? '0 : fill_next;
      end
      if (bus.clr_count) begin
        count <= match ? CNT_W'(1) : '0;
        sat   <= 1'b0;
      end else if (match && (count != CNT_MAX)) begin
        count <= count + 1'b1;
        sat   <= ((count + 1'b1) == CNT_MAX);
      end
    end
  end

  assign bus.pattern_found = found;
  assign bus.match_count   = count;
  assign bus.count_sat     = sat;
endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: vector table, directed sequences and random stream vs a queue model.
// Define MATCH_MASK_EN to also exercise the masked compare.
module tb_pattern_detector_param;
  localparam int PAT_W = 5;
  localparam int LEN_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8)) bus ();
  pattern_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) bus2 ();

  assign bus2.in_valid    = bus.in_valid;
  assign bus2.stream_in   = bus.stream_in;
  assign bus2.cfg_load    = bus.cfg_load;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_len     = bus.cfg_len;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.clr_count   = bus.clr_count;
`ifdef MATCH_MASK_EN
  assign bus2.cfg_mask    = bus.cfg_mask;
`endif

  pattern_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8), .DEF_PATTERN(5'b11010))
    dut (.clk(clk), .reset(reset), .bus(bus));
  pattern_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2), .DEF_PATTERN(5'b11010))
    dut_small (.clk(clk), .reset(reset), .bus(bus2));

  int checks   = 0;
  int failures = 0;

  // Reference model: bits received since the last clear, plus active config.
  bit             mq[$];
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_mask;
  int             m_len;
  bit             m_ovl;
  int             cnt8, cnt2;
  bit             sat8, sat2;
  bit             exp_found;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic count_model(inout int c, inout bit s, input int mx, input bit hit);
    if (bus.clr_count) begin
      c = hit ? 1 : 0;
      s = 1'b0;
    end else if (hit && c < mx) begin
      c++;
      if (c == mx) s = 1'b1;
    end
  endtask

  task automatic model_update();
    bit hit;
    int n;
    hit = 1'b0;
    if (reset) begin
      mq.delete();
      m_pat = 5'b11010; m_len = PAT_W; m_ovl = 1'b1; m_mask = '1;
      cnt8 = 0; sat8 = 1'b0; cnt2 = 0; sat2 = 1'b0; exp_found = 1'b0;
      return;
    end
    if (bus.cfg_load) begin
      m_pat = bus.cfg_pattern;
      m_len = (bus.cfg_len == 0 || int'(bus.cfg_len) > PAT_W) ? PAT_W : int'(bus.cfg_len);
      m_ovl = bus.cfg_overlap;
`ifdef MATCH_MASK_EN
      m_mask = bus.cfg_mask;
`else
      m_mask = '1;
`endif
      mq.delete();
    end else if (bus.in_valid) begin
      mq.push_back(bus.stream_in);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      n = mq.size();
      if (n >= m_len) begin
        hit = 1'b1;
        for (int j = 0; j < m_len; j++)
          if (m_mask[j] && (mq[n-1-j] != m_pat[j])) hit = 1'b0;
      end
      if (hit && !m_ovl) mq.delete();
    end
    exp_found = hit;
    count_model(cnt8, sat8, 255, hit);
    count_model(cnt2, sat2, 3, hit);
  endtask

  // One clock: advance the model on current inputs, then compare after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check("found", int'(bus.pattern_found), int'(exp_found));
    check("count8", int'(bus.match_count), cnt8);
    check("sat8", int'(bus.count_sat), int'(sat8));
    check("count2", int'(bus2.match_count), cnt2);
    check("sat2", int'(bus2.count_sat), int'(sat2));
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.stream_in = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.clr_count = 1'b0;
`ifdef MATCH_MASK_EN
    bus.cfg_mask = '1;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.in_valid = 1'b1;
    bus.stream_in = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] pm);
    pm = '0;
    for (int i = 0; i < n; i++) begin
      send_bit(bits[n-1-i]);
      if (bus.pattern_found) pm[i] = 1'b1;
    end
  endtask

  task automatic load_cfg(input logic [4:0] p, input logic [2:0] l, input logic ov, input logic [4:0] m);
    bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = ov;
`ifdef MATCH_MASK_EN
    bus.cfg_mask = m;
`else
    if (m == '0) bus.cfg_pattern = p;
`endif
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    check("load_no_pulse", int'(bus.pattern_found), 0);
  endtask

  typedef struct {
    logic v;
    logic b;
    logic exp_found;
  } vec_t;
  vec_t tbl[28];

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] s1;
    logic [31:0] pm;
    int          exp_c2[6];
    idle_inputs();
    reset = 1'b1;
    tick();
    check("reset_found", int'(bus.pattern_found), 0);
    check("reset_count", int'(bus.match_count), 0);
    reset = 1'b0;

    // Default pattern, continuous stream: 4 pulses after bits 7, 12, 22, 28.
    s1 = 28'b0011_0101_1010_0011_0110_1001_1010;
    for (int i = 0; i < 28; i++) begin
      tbl[i].v = 1'b1;
      tbl[i].b = s1[27-i];
      tbl[i].exp_found = (i == 6 || i == 11 || i == 21 || i == 27);
    end
    for (int i = 0; i < 28; i++) begin
      bus.in_valid = tbl[i].v;
      bus.stream_in = tbl[i].b;
      tick();
      check("t1_vec", int'(bus.pattern_found), int'(tbl[i].exp_found));
    end
    bus.in_valid = 1'b0;
    check("t1_count", int'(bus.match_count), 4);

    // 1010 overlapping then non-overlapping.
    load_cfg(5'b01010, 3'd4, 1'b1, 5'b11111);
    send_bits(32'b10101010, 8, pm);
    check("t2_overlap", int'(pm), 32'hA8);
    load_cfg(5'b01010, 3'd4, 1'b0, 5'b11111);
    send_bits(32'b10101010, 8, pm);
    check("t2_nonoverlap", int'(pm), 32'h88);

    // Gaps between valid bits do not break the match.
    do_reset();
    s1 = 28'b11010;
    for (int i = 0; i < 5; i++) begin
      send_bit(s1[4-i]);
      check("t3_bit", int'(bus.pattern_found), (i == 4) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        tick();
        check("t3_gap", int'(bus.pattern_found), 0);
      end
    end

    // Saturation on the 2-bit counter, then clear coinciding with a match.
    do_reset();
    exp_c2 = '{1, 2, 3, 3, 3, 3};
    for (int k = 0; k < 6; k++) begin
      send_bits(32'b11010, 5, pm);
      check("t4_count2", int'(bus2.match_count), exp_c2[k]);
      check("t4_sat2", int'(bus2.count_sat), (k >= 2) ? 1 : 0);
    end
    send_bits(32'b1101, 4, pm);
    bus.clr_count = 1'b1;
    send_bit(1'b0);
    bus.clr_count = 1'b0;
    check("t4_clr_count2", int'(bus2.match_count), 1);
    check("t4_clr_sat2", int'(bus2.count_sat), 0);
    check("t4_clr_count8", int'(bus.match_count), 1);

    // Reset mid-pattern, then length clamping at load.
    do_reset();
    send_bits(32'b1101, 4, pm);
    do_reset();
    send_bit(1'b0);
    check("t5_after_reset", int'(bus.pattern_found), 0);
    load_cfg(5'b11010, 3'd0, 1'b1, 5'b11111);
    send_bits(32'b11010, 5, pm);
    check("t5_len0", int'(pm), 32'h10);
    load_cfg(5'b11010, 3'd7, 1'b1, 5'b11111);
    send_bits(32'b01101, 5, pm);
    check("t5_len7_nohit", int'(pm), 0);

`ifdef MATCH_MASK_EN
    load_cfg(5'b11010, 3'd5, 1'b1, 5'b11101);
    send_bits(32'b11010, 5, pm);
    check("t6_mask_a", int'(pm), 32'h10);
    load_cfg(5'b11010, 3'd5, 1'b1, 5'b11101);
    send_bits(32'b11000, 5, pm);
    check("t6_mask_b", int'(pm), 32'h10);
    load_cfg(5'b11010, 3'd5, 1'b1, 5'b11101);
    send_bits(32'b01010, 5, pm);
    check("t6_mask_c", int'(pm), 0);
`endif

    // Random traffic including loads coinciding with valid bits.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 199);
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.stream_in   = $urandom_range(0, 1);
      bus.cfg_load    = (r < 6);
      bus.cfg_pattern = 5'($urandom_range(0, 31));
      bus.cfg_len     = 3'($urandom_range(0, 7));
      bus.cfg_overlap = $urandom_range(0, 1);
      bus.clr_count   = (r >= 6 && r < 10);
`ifdef MATCH_MASK_EN
      bus.cfg_mask    = 5'($urandom_range(0, 31));
`endif
      reset = (r == 199);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
